// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder datapath.
// Holds the alignment FSM encoding and the mantissa/shift widths.
package fp_pkg;

    localparam int MANT_W  = 8;
    localparam int SHIFT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMP   = 2'd1,
        ST_ALIGN = 2'd2,
        ST_DONE  = 2'd3
    } align_state_t;

endpackage

// File: rtl/barrel_shift.sv
// Shared 8-bit logical right barrel shifter used by the adder datapath.
// Shift amount k ranges 0..7; vacated bits fill with zero.
module barrel_shift
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0]  A,
    input  logic [SHIFT_W-1:0] k,
    output logic [MANT_W-1:0]  Y
);

    assign Y = A >> k;

endmodule

// File: rtl/fp_align_ctrl.sv
// Exponent-alignment sequencer: orders two operands by exponent and right-shifts
// the smaller mantissa over one or more shifter passes, tracking a sticky bit.
module fp_align_ctrl
    import fp_pkg::*;
#(
    parameter int EXP_W    = 8,
    parameter int MAX_STEP = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [7:0]        mant_a,
    input  logic [7:0]        mant_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic [7:0]        mant_big,
    output logic [7:0]        mant_small,
    output logic              sticky,
    output logic              swapped
);

    localparam logic [SHIFT_W-1:0] STEP_K     = SHIFT_W'(MAX_STEP);
    localparam logic [EXP_W-1:0]   STEP_E     = EXP_W'(MAX_STEP);
    localparam logic [EXP_W-1:0]   FLUSH_DIST = EXP_W'(MANT_W);

    align_state_t state_q, state_d;

    logic [EXP_W-1:0]  exp_out_q, exp_out_d;
    logic [EXP_W-1:0]  exp_small_q, exp_small_d;
    logic [MANT_W-1:0] mant_big_q, mant_big_d;
    logic [MANT_W-1:0] mant_small_q, mant_small_d;
    logic              sticky_q, sticky_d;
    logic              swapped_q, swapped_d;
    logic [EXP_W-1:0]  rem_q, rem_d;

    logic              cmp_swap;
    logic [EXP_W-1:0]  cmp_diff;
    logic [EXP_W-1:0]  rem_next;
    logic [SHIFT_W-1:0] shift_k;
    logic [MANT_W-1:0] shift_y;
    logic [MANT_W-1:0] sticky_mask;

    barrel_shift u_shift (
        .A (mant_small_q),
        .k (shift_k),
        .Y (shift_y)
    );

    // Per-pass shift amount; the shared shifter is idle (k=0) outside ALIGN.
    always_comb begin
        shift_k = '0;
        if (state_q == ST_ALIGN) begin
            shift_k = (rem_q < STEP_E) ? SHIFT_W'(rem_q) : STEP_K;
        end
        sticky_mask = (MANT_W'(1) << shift_k) - MANT_W'(1);
        rem_next    = rem_q - EXP_W'(shift_k);
    end

    always_comb begin
        cmp_swap = (exp_small_q > exp_out_q);
        cmp_diff = cmp_swap ? (exp_small_q - exp_out_q) : (exp_out_q - exp_small_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            exp_out_q    <= '0;
            exp_small_q  <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
            sticky_q     <= 1'b0;
            swapped_q    <= 1'b0;
            rem_q        <= '0;
        end else begin
            state_q      <= state_d;
            exp_out_q    <= exp_out_d;
            exp_small_q  <= exp_small_d;
            mant_big_q   <= mant_big_d;
            mant_small_q <= mant_small_d;
            sticky_q     <= sticky_d;
            swapped_q    <= swapped_d;
            rem_q        <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_CMP;
            end
            ST_CMP: begin
                state_d = (cmp_diff == '0 || cmp_diff >= FLUSH_DIST) ? ST_DONE : ST_ALIGN;
            end
            ST_ALIGN: begin
                if (rem_next == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are staged in the output registers on accept (A as big, B as small)
    // and exchanged in CMP when B turns out to have the larger exponent.
    always_comb begin
        exp_out_d    = exp_out_q;
        exp_small_d  = exp_small_q;
        mant_big_d   = mant_big_q;
        mant_small_d = mant_small_q;
        sticky_d     = sticky_q;
        swapped_d    = swapped_q;
        rem_d        = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    exp_out_d    = exp_a;
                    exp_small_d  = exp_b;
                    mant_big_d   = mant_a;
                    mant_small_d = mant_b;
                    sticky_d     = 1'b0;
                    swapped_d    = 1'b0;
                end
            end
            ST_CMP: begin
                swapped_d = cmp_swap;
                sticky_d  = 1'b0;
                rem_d     = cmp_diff;
                if (cmp_swap) begin
                    exp_out_d    = exp_small_q;
                    exp_small_d  = exp_out_q;
                    mant_big_d   = mant_small_q;
                    mant_small_d = mant_big_q;
                end
                if (cmp_diff >= FLUSH_DIST) begin
                    mant_small_d = '0;
                    sticky_d     = cmp_swap ? (|mant_big_q) : (|mant_small_q);
                end
            end
            ST_ALIGN: begin
                mant_small_d = shift_y;
                sticky_d     = sticky_q | (|(mant_small_q & sticky_mask));
                rem_d        = rem_next;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    assign exp_out    = exp_out_q;
    assign mant_big   = mant_big_q;
    assign mant_small = mant_small_q;
    assign sticky     = sticky_q;
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed bench for fp_align_ctrl: default instance (MAX_STEP=7) and a
// MAX_STEP=3 instance for multi-pass alignment and mid-ALIGN reset.
module tb_fp_align_ctrl;

    logic       clk;
    logic       rst;
    logic       inValid, inValid3;
    logic       outReady, outReady3;
    logic [7:0] expA, expB, mantA, mantB;

    logic       inReady0, outValid0, sticky0, swapped0;
    logic [7:0] expOut0, mantBig0, mantSmall0;
    logic       inReady3, outValid3, sticky3, swapped3;
    logic [7:0] expOut3, mantBig3, mantSmall3;

    logic       useDut3;
    logic       inReadyM, outValidM, stickyM, swappedM;
    logic [7:0] expOutM, mantBigM, mantSmallM;

    int checkCount;
    int errorCount;
    int kSeen [0:31];

    fp_align_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady0),
        .exp_a(expA), .exp_b(expB), .mant_a(mantA), .mant_b(mantB),
        .out_valid(outValid0), .out_ready(outReady),
        .exp_out(expOut0), .mant_big(mantBig0), .mant_small(mantSmall0),
        .sticky(sticky0), .swapped(swapped0)
    );

    fp_align_ctrl #(.EXP_W(8), .MAX_STEP(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(inValid3), .in_ready(inReady3),
        .exp_a(expA), .exp_b(expB), .mant_a(mantA), .mant_b(mantB),
        .out_valid(outValid3), .out_ready(outReady3),
        .exp_out(expOut3), .mant_big(mantBig3), .mant_small(mantSmall3),
        .sticky(sticky3), .swapped(swapped3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        inReadyM   = useDut3 ? inReady3   : inReady0;
        outValidM  = useDut3 ? outValid3  : outValid0;
        expOutM    = useDut3 ? expOut3    : expOut0;
        mantBigM   = useDut3 ? mantBig3   : mantBig0;
        mantSmallM = useDut3 ? mantSmall3 : mantSmall0;
        stickyM    = useDut3 ? sticky3    : sticky0;
        swappedM   = useDut3 ? swapped3   : swapped0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [7:0] eExp, input logic [7:0] eBig,
                               input logic [7:0] eSmall, input logic eSticky, input logic eSwap);
        checkOutput({tag, ".out_valid"}, outValidM, 1);
        checkOutput({tag, ".in_ready"}, inReadyM, 0);
        checkOutput({tag, ".exp_out"}, expOutM, eExp);
        checkOutput({tag, ".mant_big"}, mantBigM, eBig);
        checkOutput({tag, ".mant_small"}, mantSmallM, eSmall);
        checkOutput({tag, ".sticky"}, stickyM, eSticky);
        checkOutput({tag, ".swapped"}, swappedM, eSwap);
    endtask

    // Launch one pair, measure edges from accept (accept edge = 1) to out_valid,
    // hold backpressure for holdCycles, then hand off and confirm return to IDLE.
    task automatic applyStimulus(input string tag, input logic sel,
                                 input logic [7:0] ea, input logic [7:0] ma,
                                 input logic [7:0] eb, input logic [7:0] mb,
                                 input int expLat, input logic [7:0] eExp, input logic [7:0] eBig,
                                 input logic [7:0] eSmall, input logic eSticky, input logic eSwap,
                                 input int holdCycles);
        int lat;
        @(negedge clk);
        useDut3 = sel;
        expA = ea; mantA = ma; expB = eb; mantB = mb;
        if (sel) inValid3 = 1'b1; else inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0; inValid3 = 1'b0;
        expA = 8'hEE; mantA = 8'hEE; expB = 8'h01; mantB = 8'h5A;
        lat = 1;
        for (int i = 0; i < 32; i++) kSeen[i] = -1;
        kSeen[1] = sel ? int'(dut3.shift_k) : int'(dut.shift_k);
        while (!outValidM && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            kSeen[lat] = sel ? int'(dut3.shift_k) : int'(dut.shift_k);
        end
        checkOutput({tag, ".latency"}, lat, expLat);
        checkResult(tag, eExp, eBig, eSmall, eSticky, eSwap);
        for (int h = 0; h < holdCycles; h++) begin
            @(posedge clk);
            #1;
            checkResult({tag, ".hold"}, eExp, eBig, eSmall, eSticky, eSwap);
        end
        @(negedge clk);
        if (sel) outReady3 = 1'b1; else outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0; outReady3 = 1'b0;
        checkOutput({tag, ".idle_in_ready"}, inReadyM, 1);
        checkOutput({tag, ".idle_out_valid"}, outValidM, 0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        useDut3 = 1'b0;
        inValid = 1'b0; inValid3 = 1'b0;
        outReady = 1'b0; outReady3 = 1'b0;
        expA = '0; expB = '0; mantA = '0; mantB = '0;
        rst = 1'b1;
        #1;
        checkOutput("reset.in_ready", inReady0, 1);
        checkOutput("reset.out_valid", outValid0, 0);
        checkOutput("reset.exp_out", expOut0, 0);
        checkOutput("reset.mant_small", mantSmall0, 0);
        checkOutput("reset.sticky", sticky0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus("basic", 1'b0, 8'h85, 8'hC0, 8'h83, 8'hA0, 3, 8'h85, 8'hC0, 8'h28, 1'b0, 1'b0, 0);
        applyStimulus("swap_sticky", 1'b0, 8'h10, 8'hFF, 8'h17, 8'h80, 3, 8'h17, 8'h80, 8'h01, 1'b1, 1'b1, 0);
        applyStimulus("flush", 1'b0, 8'h80, 8'h81, 8'h8A, 8'hF0, 2, 8'h8A, 8'hF0, 8'h00, 1'b1, 1'b1, 0);
        applyStimulus("flush_rem8", 1'b0, 8'h10, 8'h55, 8'h08, 8'h01, 2, 8'h10, 8'h55, 8'h00, 1'b1, 1'b0, 0);
        applyStimulus("tie_bp", 1'b0, 8'h44, 8'h11, 8'h44, 8'h22, 2, 8'h44, 8'h11, 8'h22, 1'b0, 1'b0, 5);

        applyStimulus("multipass", 1'b1, 8'h20, 8'h40, 8'h25, 8'h7F, 4, 8'h25, 8'h7F, 8'h02, 1'b0, 1'b1, 0);
        checkOutput("multipass.k_cmp", kSeen[1], 0);
        checkOutput("multipass.k_pass1", kSeen[2], 3);
        checkOutput("multipass.k_pass2", kSeen[3], 2);
        applyStimulus("step_edge", 1'b1, 8'h03, 8'h0F, 8'h00, 8'h0F, 3, 8'h03, 8'h0F, 8'h01, 1'b1, 1'b0, 0);

        // Reset while dut3 is in its first ALIGN pass.
        @(negedge clk);
        useDut3 = 1'b1;
        expA = 8'h20; mantA = 8'h40; expB = 8'h25; mantB = 8'h7F;
        inValid3 = 1'b1;
        @(posedge clk);
        #1;
        inValid3 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_mid.k_before", dut3.shift_k, 3);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid.in_ready", inReady3, 1);
        checkOutput("rst_mid.out_valid", outValid3, 0);
        checkOutput("rst_mid.exp_out", expOut3, 0);
        checkOutput("rst_mid.mant_big", mantBig3, 0);
        checkOutput("rst_mid.mant_small", mantSmall3, 0);
        checkOutput("rst_mid.swapped", swapped3, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_mid.no_result", outValid3, 0);
        end
        applyStimulus("after_rst", 1'b1, 8'h20, 8'h40, 8'h25, 8'h7F, 4, 8'h25, 8'h7F, 8'h02, 1'b0, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fp_align_ctrl.md
# fp_align_ctrl

Exponent-alignment sequencer for the floating-point adder. It accepts two (exponent, 8-bit mantissa) operands and orders them so the larger exponent is first. It then drives the shared 8-bit `barrel_shift` unit over one or more passes to right-shift the smaller operand's mantissa by the exponent difference, accumulating a sticky bit. The aligned pair is presented to the adder stage through a valid/ready handshake.

## Interface
- `EXP_W`, default 8: exponent width.
- `MAX_STEP`, default 7: maximum shift per pass. Legal range 1..7, bounded by the shifter's 3-bit `k`.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: controller can accept; high only in IDLE.
- `exp_a`, `exp_b`  in  EXP_W: operand exponents (unsigned, biased).
- `mant_a`, `mant_b`  in  8: operand mantissas.
- `out_valid`  out  1: aligned result valid; high only in DONE.
- `out_ready`  in  1: consumer accepts the result.
- `exp_out`  out  EXP_W: common (larger) exponent.
- `mant_big`  out  8: mantissa of the larger-exponent operand, unshifted.
- `mant_small`  out  8: aligned mantissa of the smaller-exponent operand.
- `sticky`  out  1: OR of every bit shifted out of `mant_small`.
- `swapped`  out  1: 1 when operand B had the strictly larger exponent.

## Operation
- **States:** IDLE, CMP, ALIGN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - `in_valid`&`in_ready` latches all four operand inputs and moves to CMP.
- **CMP:** one cycle.
  - If `exp_b` > `exp_a`: swap the operands and set `swapped`=1. Ties do not swap.
  - `rem` = larger exponent − smaller exponent, an unsigned EXP_W-bit register.
  - `sticky` is cleared.
  - If `rem`=0: go to DONE.
  - If `rem`≥8 (flush): `mant_small`=0, `sticky`=(small mantissa≠0), go to DONE.
  - Otherwise: go to ALIGN.
- **ALIGN:** one pass per cycle.
  - `k` = min(`rem`, `MAX_STEP`).
  - `mant_small` ← `barrel_shift`(`mant_small`, `k`).
  - `sticky` |= OR of the low `k` bits of `mant_small` before the shift.
  - `rem` ← `rem` − `k`.
  - Go to DONE when the new `rem` is 0; otherwise stay in ALIGN.
- **DONE:**
  - `out_valid`=1 and the outputs are held stable until `out_ready`.
  - `out_valid`&`out_ready` returns to IDLE.
  - No new operand is accepted in the same cycle as the handoff.
- **Shifter usage:** `k` is driven to 0 whenever the state is not ALIGN.
- **Reset values (all outputs):** state=IDLE, `in_ready`=1, `out_valid`=0, all data outputs 0.
- **Reset mid-operation:** the in-flight pair is discarded and no `out_valid` is produced for it.
- **Input stability:** input changes while not in IDLE are ignored.

## Timing
- **Accept:** on the edge where `in_valid`&`in_ready`.
- **Latency (accept edge to first cycle with `out_valid` high):**
  - 2 cycles for `rem`=0 or flush.
  - 2 + ceil(`rem`/`MAX_STEP`) cycles otherwise.
- **Throughput:** one operation per latency + 1 cycles, because the return to IDLE costs one cycle.
- **Outputs:** registered, with no combinational path from inputs to outputs. `in_ready` and `out_valid` decode directly from the state register.
- **Backpressure:** DONE holds indefinitely with all outputs frozen.

## Structure
- **Shared package (`fp_pkg`):**
  - State encoding: 2-bit IDLE=0, CMP=1, ALIGN=2, DONE=3.
  - `MANT_W`=8 and `SHIFT_W`=3, shared with the adder datapath.
- **Sub-module:** exactly one instance of the existing `barrel_shift` (8-bit `A`, 3-bit `k`). No additional shifter.
- **Sticky mask:** the mask ((1<<`k`)−1) is computed locally.

## Test plan
- **Basic, no swap:** `exp_a`=0x85, `mant_a`=0xC0, `exp_b`=0x83, `mant_b`=0xA0 -> `exp_out`=0x85, `mant_big`=0xC0, `mant_small`=0x28, `sticky`=0, `swapped`=0. `out_valid` 3 cycles after accept.
- **Swap, sticky:** `exp_a`=0x10, `mant_a`=0xFF, `exp_b`=0x17, `mant_b`=0x80 -> `swapped`=1, `exp_out`=0x17, `mant_big`=0x80, `mant_small`=0x01, `sticky`=1. Latency 3.
- **Flush:** `exp_a`=0x80, `mant_a`=0x81, `exp_b`=0x8A, `mant_b`=0xF0 -> `mant_small`=0x00, `sticky`=1, `swapped`=1, `exp_out`=0x8A. Latency 2.
- **Multi-pass (`MAX_STEP`=3):** `exp_a`=0x20, `mant_a`=0x40, `exp_b`=0x25, `mant_b`=0x7F -> shifter sees `k`=3 then `k`=2. Result: `swapped`=1, `mant_big`=0x7F, `mant_small`=0x02, `sticky`=0. Latency 4.
- **Tie plus backpressure:** equal exponents 0x44, `mant_a`=0x11, `mant_b`=0x22, `out_ready`=0 for 5 cycles -> `mant_small`=0x22, `swapped`=0. `out_valid` and data are stable for all 5 cycles. `in_ready`=0 throughout and returns to 1 the cycle after `out_ready`.
- **Reset mid-ALIGN:** assert `rst` in an ALIGN cycle -> `in_ready`=1, `out_valid`=0, data outputs 0 immediately, with no result for that pair. The next operation completes normally.
